// File: rtl/tag_rx_hop_integrator.sv
// tag_rx_hop_integrator: per-hop I/Q integrator with settling skip and a valid/ready result register
module tag_rx_hop_integrator #(
  parameter int DATA_WIDTH  = 16,
  parameter int ACC_WIDTH   = 32,
  parameter int NUM_HOPS    = 64,
  parameter int SAMPLE_SKIP = 16,
  parameter int HIW         = $clog2(NUM_HOPS)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [1:0]                   rx_state_i,
  input  logic                         in_valid_i,
  input  logic signed [DATA_WIDTH-1:0] irx_i,
  input  logic signed [DATA_WIDTH-1:0] qrx_i,
  input  logic                         out_ready_i,
  input  logic                         clear_overrun_i,
  output logic                         out_valid_o,
  output logic signed [ACC_WIDTH-1:0]  acc_i_o,
  output logic signed [ACC_WIDTH-1:0]  acc_q_o,
  output logic [DATA_WIDTH-1:0]        n_samples_o,
  output logic [HIW-1:0]               hop_idx_o,
  output logic                         frame_last_o,
  output logic                         sat_o,
  output logic                         overrun_o,
  output logic                         busy_o
);
  localparam int SW = SAMPLE_SKIP > 0 ? $clog2(SAMPLE_SKIP + 1) : 1;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [HIW-1:0] HOP_LAST = HIW'(NUM_HOPS - 1);

  typedef enum logic [1:0] {IDLE, SKIP, ACCUM} state_e;

  state_e                 state_q;
  logic [SW-1:0]          skip_q, skip_d, skip_base;
  logic [ACC_WIDTH-1:0]   ai_q, aq_q, ai_d, aq_d, ai_base, aq_base;
  logic [ACC_WIDTH:0]     ai_sum, aq_sum;
  logic [DATA_WIDTH-1:0]  cnt_q, cnt_d, cnt_base;
  logic [HIW-1:0]         hop_q;
  logic                   sat_q, clip_ai, clip_aq, hop_rx, take, entry_acc;

  // Saturating next-sum and skip countdown; from IDLE the window starts from zero
  always_comb begin
    hop_rx    = rx_state_i == 2'b11;
    take      = hop_rx && in_valid_i;
    entry_acc = take && SAMPLE_SKIP == 0;
    ai_base   = state_q == IDLE ? '0 : ai_q;
    aq_base   = state_q == IDLE ? '0 : aq_q;
    cnt_base  = state_q == IDLE ? '0 : cnt_q;
    skip_base = state_q == IDLE ? SW'(SAMPLE_SKIP) : skip_q;
    skip_d    = skip_base - SW'(take);
    ai_sum    = {ai_base[ACC_WIDTH-1], ai_base} + {{(ACC_WIDTH+1-DATA_WIDTH){irx_i[DATA_WIDTH-1]}}, irx_i};
    aq_sum    = {aq_base[ACC_WIDTH-1], aq_base} + {{(ACC_WIDTH+1-DATA_WIDTH){qrx_i[DATA_WIDTH-1]}}, qrx_i};
    clip_ai   = ai_sum[ACC_WIDTH] ^ ai_sum[ACC_WIDTH-1];
    clip_aq   = aq_sum[ACC_WIDTH] ^ aq_sum[ACC_WIDTH-1];
    ai_d      = clip_ai ? (ai_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : ai_sum[ACC_WIDTH-1:0];
    aq_d      = clip_aq ? (aq_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : aq_sum[ACC_WIDTH-1:0];
    cnt_d     = &cnt_base ? cnt_base : cnt_base + 1'b1;
  end

  // Window FSM, accumulators, hop counter and the registered result/handshake outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      skip_q       <= '0;
      ai_q         <= '0;
      aq_q         <= '0;
      cnt_q        <= '0;
      sat_q        <= 1'b0;
      hop_q        <= '0;
      out_valid_o  <= 1'b0;
      acc_i_o      <= '0;
      acc_q_o      <= '0;
      n_samples_o  <= '0;
      hop_idx_o    <= '0;
      frame_last_o <= 1'b0;
      sat_o        <= 1'b0;
      overrun_o    <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      if (out_ready_i) out_valid_o <= 1'b0;
      overrun_o <= overrun_o && !clear_overrun_i;
      case (state_q)
        IDLE: if (hop_rx) begin
          state_q <= (SAMPLE_SKIP == 0 || skip_d == '0) ? ACCUM : SKIP;
          busy_o  <= 1'b1;
          skip_q  <= skip_d;
          ai_q    <= entry_acc ? ai_d : '0;
          aq_q    <= entry_acc ? aq_d : '0;
          cnt_q   <= entry_acc ? cnt_d : '0;
          sat_q   <= entry_acc && (clip_ai || clip_aq);
        end
        SKIP, ACCUM: if (!hop_rx) begin
          state_q      <= IDLE;
          busy_o       <= 1'b0;
          out_valid_o  <= 1'b1;
          acc_i_o      <= ai_q;
          acc_q_o      <= aq_q;
          n_samples_o  <= cnt_q;
          hop_idx_o    <= hop_q;
          frame_last_o <= hop_q == HOP_LAST;
          sat_o        <= sat_q;
          overrun_o    <= (out_valid_o && !out_ready_i) || (overrun_o && !clear_overrun_i);
          hop_q        <= hop_q == HOP_LAST ? '0 : hop_q + 1'b1;
        end else if (take && state_q == SKIP) begin
          skip_q <= skip_d;
          if (skip_d == '0) state_q <= ACCUM;
        end else if (take) begin
          ai_q  <= ai_d;
          aq_q  <= aq_d;
          cnt_q <= cnt_d;
          sat_q <= sat_q || clip_ai || clip_aq;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tag_rx_hop_integrator.sv
// tb_tag_rx_hop_integrator: directed vector bench for the per-hop I/Q integrator
module tb_tag_rx_hop_integrator;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] rx = 2'b00;
  logic vld = 1'b0, rdy = 1'b0, clr = 1'b0;
  logic signed [15:0] ii = '0, qq = '0;
  logic ov, fl, st, orn, bsy;
  logic signed [31:0] ai, aq;
  logic [15:0] ns;
  logic [5:0] hop;
  logic ov20, fl20, st20, orn20, bsy20;
  logic signed [19:0] ai20, aq20;
  logic [15:0] ns20;
  logic [5:0] hop20;
  int cmp = 0, errs = 0;

  tag_rx_hop_integrator dut (
    .clk_i(clk), .rst_ni(rst_n), .rx_state_i(rx), .in_valid_i(vld), .irx_i(ii), .qrx_i(qq),
    .out_ready_i(rdy), .clear_overrun_i(clr), .out_valid_o(ov), .acc_i_o(ai), .acc_q_o(aq),
    .n_samples_o(ns), .hop_idx_o(hop), .frame_last_o(fl), .sat_o(st), .overrun_o(orn), .busy_o(bsy)
  );

  tag_rx_hop_integrator #(.ACC_WIDTH(20)) dut20 (
    .clk_i(clk), .rst_ni(rst_n), .rx_state_i(rx), .in_valid_i(vld), .irx_i(ii), .qrx_i(qq),
    .out_ready_i(rdy), .clear_overrun_i(clr), .out_valid_o(ov20), .acc_i_o(ai20), .acc_q_o(aq20),
    .n_samples_o(ns20), .hop_idx_o(hop20), .frame_last_o(fl20), .sat_o(st20), .overrun_o(orn20), .busy_o(bsy20)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len; int iv; int qv;
    int n; longint ea; longint eq;
  } vec_t;
  vec_t vt[5];

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string nm, input logic signed [63:0] a, input logic signed [63:0] e);
    cmp++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  // len HOP_RX cycles with constant samples, then one INIT cycle whose edge closes the window
  task automatic window(input int len, input int iv, input int qv);
    rx = 2'b11; vld = 1'b1; ii = 16'(iv); qq = 16'(qv);
    cyc(1);
    chk("busy_open", bsy, 1);
    cyc(len - 1);
    rx = 2'b00; vld = 1'b0;
    cyc(1);
    chk("busy_closed", bsy, 0);
  endtask

  initial begin
    vt[0] = '{16385, 100, -50, 16369, 1636900, -818450};
    vt[1] = '{10, 1234, -99, 0, 0, 0};
    vt[2] = '{17, -7, 3, 1, -7, 3};
    vt[3] = '{16, 5, 5, 0, 0, 0};
    vt[4] = '{20, -32768, 32767, 4, -131072, 131068};

    #12;
    chk("rst_valid", ov, 0);
    chk("rst_acc_i", ai, 0);
    chk("rst_acc_q", aq, 0);
    chk("rst_n", ns, 0);
    chk("rst_hop", hop, 0);
    chk("rst_last", fl, 0);
    chk("rst_sat", st, 0);
    chk("rst_overrun", orn, 0);
    chk("rst_busy", bsy, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    cyc(2);

    rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      window(vt[k].len, vt[k].iv, vt[k].qv);
      chk("vec_valid", ov, 1);
      chk("vec_acc_i", ai, vt[k].ea);
      chk("vec_acc_q", aq, vt[k].eq);
      chk("vec_n", ns, vt[k].n);
      chk("vec_hop", hop, k);
      chk("vec_last", fl, 0);
      chk("vec_sat", st, 0);
      cyc(1);
      chk("vec_valid_drop", ov, 0);
    end

    // reset mid-ACCUM discards the window and restarts the hop counter
    rx = 2'b11; vld = 1'b1; ii = 16'sd5; qq = 16'sd5;
    cyc(30);
    rx = 2'b00; vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", ov, 0);
    chk("mid_rst_acc_i", ai, 0);
    chk("mid_rst_acc_q", aq, 0);
    chk("mid_rst_n", ns, 0);
    chk("mid_rst_hop", hop, 0);
    chk("mid_rst_busy", bsy, 0);
    #2 rst_n = 1'b1;
    cyc(3);
    chk("mid_rst_no_record", ov, 0);
    window(20, 2, -3);
    chk("post_rst_acc_i", ai, 8);
    chk("post_rst_acc_q", aq, -12);
    chk("post_rst_hop", hop, 0);
    chk("post_rst_last", fl, 0);

    // back-to-back windows through the hop wrap
    for (int k = 1; k <= 64; k++) begin
      window(100, 1, 1);
      chk("wrap_valid", ov, 1);
      chk("wrap_hop", hop, k % 64);
      chk("wrap_last", fl, (k % 64) == 63);
      chk("wrap_n", ns, 84);
    end
    cyc(1);

    // saturation in the narrow accumulator, cleared on the next hop
    window(116, 32767, 0);
    chk("sat20_acc_i", ai20, 524287);
    chk("sat20_flag", st20, 1);
    chk("sat20_n", ns20, 100);
    chk("wide_acc_i", ai, 3276700);
    chk("wide_sat", st, 0);
    cyc(1);
    window(20, 1, 1);
    chk("sat20_clean", st20, 0);
    chk("sat20_clean_acc", ai20, 4);
    cyc(1);

    // overrun: two records without acceptance
    rdy = 1'b0;
    window(20, 1, 1);
    cyc(1);
    chk("ovr_first_held", ov, 1);
    chk("ovr_not_yet", orn, 0);
    window(30, 2, 0);
    chk("ovr_valid", ov, 1);
    chk("ovr_set", orn, 1);
    chk("ovr_newest_n", ns, 14);
    chk("ovr_newest_acc", ai, 28);
    cyc(3);
    chk("ovr_stable_acc", ai, 28);
    chk("ovr_stable_n", ns, 14);
    chk("ovr_stable_valid", ov, 1);
    clr = 1'b1; cyc(1); clr = 1'b0;
    chk("ovr_cleared", orn, 0);
    chk("ovr_clear_keeps_valid", ov, 1);

    // acceptance in the load cycle: replace, no overrun
    rx = 2'b11; vld = 1'b1; ii = 16'sd3; qq = 16'sd0;
    cyc(20);
    rx = 2'b00; vld = 1'b0; rdy = 1'b1;
    cyc(1);
    rdy = 1'b0;
    chk("accept_load_valid", ov, 1);
    chk("accept_load_overrun", orn, 0);
    chk("accept_load_acc", ai, 12);
    chk("accept_load_n", ns, 4);

    // set and clear in the same cycle: set wins
    rx = 2'b11; vld = 1'b1; ii = -16'sd1;
    cyc(20);
    rx = 2'b00; vld = 1'b0; clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("set_wins_overrun", orn, 1);
    chk("set_wins_acc", ai, -4);
    rdy = 1'b1; clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("final_overrun", orn, 0);
    chk("final_valid", ov, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
